// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 codes, FSM states
// and the register-file write-enable values.
package riscv_constants;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_funct_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } md_state_e;

    typedef enum logic {
        RF_X     = 1'b0,
        RF_WRITE = 1'b1
    } rf_wen_e;

    function automatic logic md_is_div(input md_funct_e f);
        return (f == MD_DIV) || (f == MD_DIVU) || (f == MD_REM) || (f == MD_REMU);
    endfunction

    function automatic logic md_is_signed_div(input md_funct_e f);
        return (f == MD_DIV) || (f == MD_REM);
    endfunction

    function automatic logic md_is_rem(input md_funct_e f);
        return (f == MD_REM) || (f == MD_REMU);
    endfunction

endpackage

// File: rtl/riscv_muldiv_div_core.sv
// Unsigned restoring divider: one quotient bit per clock, 32 iterations after load.
module riscv_div_core #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic [WORD_LENGTH-1:0] quotient,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   last
);

    localparam int W     = WORD_LENGTH;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    logic [W-1:0]     quo_q, rem_q, dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic [W:0]       trial, diff;
    logic             fits;

    // Bit W of the 33-bit difference is the borrow: set when the trial is below the divisor.
    always_comb begin
        trial = {rem_q, quo_q[W-1]};
        diff  = trial - {1'b0, dsr_q};
        fits  = ~diff[W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            quo_q    <= dividend;
            rem_q    <= '0;
            dsr_q    <= divisor;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            rem_q <= fits ? diff[W-1:0] : trial[W-1:0];
            quo_q <= {quo_q[W-2:0], fits};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                active_q <= 1'b0;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = active_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/riscv_muldiv.sv
// RV32M execute-stage unit: single-cycle registered multiply, 32-cycle divide with
// sign fix-up, and an immediate path for divide-by-zero and signed overflow.
module riscv_muldiv
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_LENGTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             funct,
    input  logic [WORD_LENGTH-1:0] op_a,
    input  logic [WORD_LENGTH-1:0] op_b,
    input  logic [ADDR_LENGTH-1:0] rd_in,
    output logic                   busy,
    output rf_wen_e                write_en,
    output logic [ADDR_LENGTH-1:0] write_addr,
    output logic [WORD_LENGTH-1:0] result
);

    localparam int W = WORD_LENGTH;
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = '1;

    md_state_e              state_q, state_d;
    md_funct_e              funct_q;
    logic [W-1:0]           a_q, b_q, result_q;
    logic [ADDR_LENGTH-1:0] rd_q, write_addr_q;
    logic                   q_neg_q, r_neg_q, busy_q;
    rf_wen_e                wen_q;

    md_funct_e    funct_in;
    logic         is_div_in, sdiv_in, special_in, div_zero_in, accept, div_load;
    logic [W-1:0] special_res, dividend_d, divisor_d;

    always_comb begin
        funct_in    = md_funct_e'(funct);
        is_div_in   = md_is_div(funct_in);
        sdiv_in     = md_is_signed_div(funct_in);
        div_zero_in = (op_b == '0);
        special_in  = is_div_in &&
                      (div_zero_in || (sdiv_in && op_a == MIN_NEG && op_b == ALL_ONES));
        accept      = (state_q == ST_IDLE) && start;
        div_load    = accept && is_div_in && !special_in;
        dividend_d  = (sdiv_in && op_a[W-1]) ? -op_a : op_a;
        divisor_d   = (sdiv_in && op_b[W-1]) ? -op_b : op_b;
        // Overflow case: quotient is the dividend itself, remainder is zero.
        if (md_is_rem(funct_in)) begin
            special_res = div_zero_in ? op_a : '0;
        end else begin
            special_res = div_zero_in ? ALL_ONES : MIN_NEG;
        end
    end

    logic [W-1:0] div_quo, div_rem, div_res;
    logic         div_last;

    riscv_div_core #(.WORD_LENGTH(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .dividend  (dividend_d),
        .divisor   (divisor_d),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // The top two bits of the 66-bit signed product are never selected, so the
    // 33-bit extended operands are multiplied in a 64-bit signed context.
    logic              a_sgn, b_sgn;
    logic signed [2*W-1:0] a_x, b_x, prod;
    logic [W-1:0]      mul_res;

    always_comb begin
        a_sgn   = (funct_q == MD_MULH) || (funct_q == MD_MULHSU);
        b_sgn   = (funct_q == MD_MULH);
        a_x     = {{W{a_sgn & a_q[W-1]}}, a_q};
        b_x     = {{W{b_sgn & b_q[W-1]}}, b_q};
        prod    = a_x * b_x;
        mul_res = (funct_q == MD_MUL) ? prod[W-1:0] : prod[2*W-1:W];
        if (md_is_rem(funct_q)) begin
            div_res = r_neg_q ? -div_rem : div_rem;
        end else begin
            div_res = q_neg_q ? -div_quo : div_quo;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!is_div_in)     state_d = ST_MUL;
                    else if (special_in) state_d = ST_DONE;
                    else                state_d = ST_DIV;
                end
            end
            ST_MUL:  state_d = ST_DONE;
            ST_DIV:  if (div_last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            wen_q        <= RF_X;
            result_q     <= '0;
            write_addr_q <= '0;
            funct_q      <= MD_MUL;
            a_q          <= '0;
            b_q          <= '0;
            rd_q         <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            wen_q   <= (state_d == ST_DONE) ? RF_WRITE : RF_X;
            if (accept) begin
                funct_q <= funct_in;
                a_q     <= op_a;
                b_q     <= op_b;
                rd_q    <= rd_in;
                q_neg_q <= sdiv_in && (op_a[W-1] ^ op_b[W-1]);
                r_neg_q <= sdiv_in && op_a[W-1];
            end
            case (state_q)
                ST_IDLE: begin
                    if (start && special_in) begin
                        result_q     <= special_res;
                        write_addr_q <= rd_in;
                    end
                end
                ST_MUL: begin
                    result_q     <= mul_res;
                    write_addr_q <= rd_q;
                end
                ST_FIX: begin
                    result_q     <= div_res;
                    write_addr_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_q;
    assign write_en   = wen_q;
    assign write_addr = write_addr_q;
    assign result     = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Bench for riscv_muldiv: fixed vector table, hand-built reset/ignore sequences
// and random operations checked against an arithmetic reference model.
module tb_riscv_muldiv;
    import riscv_constants::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  funct;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy;
    rf_wen_e     write_en;
    logic [4:0]  write_addr;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    riscv_muldiv #(.WORD_LENGTH(32), .ADDR_LENGTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .funct      (funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .rd_in      (rd_in),
        .busy       (busy),
        .write_en   (write_en),
        .write_addr (write_addr),
        .result     (result)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        case (f)
            MD_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    return (b == 0) ? a : 32'(sa % sb);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f == MD_MUL || f == MD_MULH || f == MD_MULHSU || f == MD_MULHU) return 2;
        if (b == 0) return 1;
        if ((f == MD_DIV || f == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Call just after the accepting edge; waits for the DONE pulse and checks it.
    task automatic wait_done(input string name, input logic [4:0] rd, input int exp_lat);
        int          lat;
        logic [31:0] got, exp;
        logic [4:0]  waddr;
        lat   = 0;
        got   = 'x;
        waddr = 'x;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 1) check({name, " busy"}, 32'(busy), 32'd1);
            if (write_en == RF_WRITE) begin
                lat   = n;
                got   = result;
                waddr = write_addr;
                break;
            end
        end
        check({name, " latency"}, lat, exp_lat);
        exp = exp_q.pop_front();
        check({name, " result"}, got, exp);
        check({name, " waddr"}, 32'(waddr), 32'(rd));
        @(negedge clk);
        check({name, " wen_after"}, 32'(write_en), 32'(RF_X));
        check({name, " busy_after"}, 32'(busy), 32'd0);
        check({name, " hold"}, result, exp);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        exp_q.push_back(exp);
        @(negedge clk);
        funct = f;
        op_a  = a;
        op_b  = b;
        rd_in = rd;
        start = 1'b1;
        @(posedge clk);
        wait_done(name, rd, exp_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          writes, first_lat;
        logic [31:0] first_res;
        logic        seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2};
        vecs[1]  = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 2};
        vecs[2]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 2};
        vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 2};
        vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 34};
        vecs[5]  = '{MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 34};
        vecs[6]  = '{MD_DIVU,   32'd100,       32'd7,         5'd7,  32'd14,        34};
        vecs[7]  = '{MD_REMU,   32'd100,       32'd7,         5'd8,  32'd2,         34};
        vecs[8]  = '{MD_DIVU,   32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{MD_REM,    32'd5,         32'd0,         5'd10, 32'd5,         1};
        vecs[10] = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0,         1};
        vecs[12] = '{MD_MUL,    32'h0001_2345, 32'h0000_0010, 5'd0,  32'h0012_3450, 2};
        vecs[13] = '{MD_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 32'hFFFF_FFFF, 34};
        vecs[14] = '{MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 34};
        vecs[15] = '{MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 5'd14, 32'h0000_0001, 34};

        rst   = 1'b1;
        start = 1'b0;
        funct = '0;
        op_a  = '0;
        op_b  = '0;
        rd_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset wen", 32'(write_en), 32'(RF_X));
        check("reset waddr", 32'(write_addr), 32'd0);
        check("reset result", result, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].rd, vecs[i].exp, vecs[i].lat);
        end

        // A second request mid-divide must be ignored: one write, original result.
        @(negedge clk);
        funct = MD_DIVU; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20; start = 1'b1;
        @(posedge clk);
        writes = 0; first_lat = 0; first_res = 'x;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (write_en == RF_WRITE) begin
                writes++;
                if (writes == 1) begin
                    first_lat = n;
                    first_res = result;
                end
            end
            start = (n == 5);
            if (n == 5) begin
                funct = MD_MUL; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd21;
            end
        end
        check("ignore writes", writes, 1);
        check("ignore latency", first_lat, 34);
        check("ignore result", first_res, 32'd333);

        // Reset during a divide drops it; the next request at T+11 runs normally.
        @(negedge clk);
        funct = MD_DIV; op_a = 32'd5000; op_b = 32'd7; rd_in = 5'd22; start = 1'b1;
        @(posedge clk);
        writes = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (write_en == RF_WRITE) writes++;
            if (n == 10) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst wen", 32'(write_en), 32'(RF_X));
        check("rst result", result, 32'd0);
        check("rst writes", writes, 0);
        exp_q.push_back(32'd42);
        funct = MD_MUL; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd23; start = 1'b1;
        @(posedge clk);
        wait_done("post_rst mul", 5'd23, 2);

        // Reset and start together: reset wins and nothing is accepted.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; funct = MD_MUL; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd24;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (busy || write_en == RF_WRITE) seen = 1'b1;
        end
        check("rst_start activity", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = rnd_op();
            rb = rnd_op();
            run_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb, 5'($urandom_range(0, 31)),
                   model(rf, ra, rb), lat_model(rf, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Multi-cycle RV32M multiply/divide unit for the execute stage. It consumes the two operand words read from `riscv_regs` and produces a result for the register-file write port, asserting `write_en` for exactly one cycle. Multiplies use one registered product cycle. Divides and remainders use a 32-iteration restoring divider. The core stalls on `busy`.

## Interface
Parameters:
- `WORD_LENGTH`, 32, operand/result width (only 32 supported)
- `ADDR_LENGTH`, 5, register address width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request valid; accepted only in IDLE
- `funct`  in  3  `MD_FUNCT`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- `op_a`  in  WORD_LENGTH  rs1 value (dividend / multiplicand)
- `op_b`  in  WORD_LENGTH  rs2 value (divisor / multiplier)
- `rd_in`  in  ADDR_LENGTH  destination register
- `busy`  out  1  high in every state except IDLE
- `write_en`  out  `RF_WEN`  RF_WRITE in DONE, else RF_X
- `write_addr`  out  ADDR_LENGTH  latched `rd_in`
- `result`  out  WORD_LENGTH  result; valid when `write_en == RF_WRITE`

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + `start`:
  - Latch `funct`, `op_a`, `op_b`, `rd_in`.
  - MUL* goes to MUL.
  - DIV*/REM* with divisor 0 or signed overflow goes straight to DONE.
  - Other DIV*/REM* goes to DIV.
- MUL: form a 66-bit product from 33-bit extended operands.
  - Signed × signed for MULH; signed × zero-extended for MULHSU; zero-extended for MUL and MULHU.
  - MUL takes bits [31:0]; the others take bits [63:32].
  - Go to DONE.
- DIV: restoring unsigned division of |a| by |b|.
  - Use |x| only for DIV/REM; DIVU/REMU use raw operands.
  - One quotient bit per cycle, 32 cycles, counter 0..31; go to FIX when the counter reaches 31.
- FIX:
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend is negative.
  - Select the quotient for DIV*, the remainder for REM*; go to DONE.
- Special cases, per the RISC-V spec:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = `op_a`.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE: `write_en` = RF_WRITE for one cycle, then IDLE.
- `start` while `busy` is ignored; it is neither queued nor latched.
- `rd_in == 0` is still computed and written; the register file discards the x0 write.
- Arithmetic is mod 2^32, with no overflow flag.

## Timing
- Reset values: state IDLE, `busy` 0, `write_en` RF_X, `write_addr` 0, `result` 0.
- `start` sampled at edge T. Response cycles:
  - MUL*: DONE in cycle T+2.
  - DIV*/REM*: DIV in T+1..T+32, FIX in T+33, DONE in T+34.
  - Special case: DONE in T+1.
- `busy` rises in the cycle after acceptance and falls the cycle after DONE.
- `start` is next accepted in the first IDLE cycle, i.e. DONE+1.
- `result` and `write_addr` are registered and hold their value after DONE until the next DONE.
- `rst` during any state: IDLE on the next edge.
  - No DONE pulse is issued and the in-flight op is discarded.
  - `result` is cleared to 0.
- `rst` and `start` in the same cycle: `rst` wins and the request is dropped.

## Structure
- `riscv_constants` gains:
  - `MD_FUNCT` enum, encoded as RV32M funct3.
  - `MD_STATE` enum.
  - `RF_WEN` value RF_X, the non-write value.
- Sub-module `riscv_div_core`:
  - 32-iteration unsigned restoring divider.
  - Inputs: `clk`, `rst`, `load`, dividend, divisor.
  - Outputs: quotient, remainder, `last`.
- `riscv_muldiv` holds the FSM, the sign handling, the multiplier and the result mux.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → DONE at T+2, `result` 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD at T+34; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → DONE at T+1, 0xFFFFFFFF; REM 5 / 0 → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Second `start` pulsed at T+5 during a DIV is ignored and only one write occurs.
- `rst` at T+10 of a DIV → IDLE at T+11, no `write_en`; a new MUL accepted at T+11 completes normally.
- `rd_in` = 0 and `rd_in` = 31 → `write_addr` matches for each.
